dvp_timing_gen: RTL and testbench
=================================

# dvp_timing_gen

Synthesizable DVP (OV5642-style) sensor-side timing generator: drives `vsync`, `href` and an 8-bit pixel byte stream on `px_clk`, matching what the camera-interface capture logic expects from the real sensor. It is used as an on-chip loopback source for bring-up and as the stimulus master in capture-path benches. It emits a programmable number of frames of a deterministic test pattern after a start pulse, then returns to idle.

## Interface
- `H_ACTIVE`, 640: pixel clocks per line with `href` high (multiple of 8, ≥ 8).
- `H_BLANK`, 160: pixel clocks per line with `href` low (≥ 1).
- `V_ACTIVE`, 480: lines with active `href`.
- `VSYNC_LINES`, 4: lines with `vsync` high.
- `V_BACK`, 16: blank lines between `vsync` fall and the first active line (≥ 1).
- `V_FRONT`, 8: blank lines after the last active line (≥ 1).
- `px_clk`  in  1  pixel clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `num_frames`  in  8  frames to emit, latched on accepted `start`; 0 = continuous.
- `stop_req`  in  1  level; finish current frame, then go to IDLE.
- `pattern_sel`  in  1  0 = gradient, 1 = colour bars (see Configuration).
- `vsync`  out  1  frame sync, active high.
- `href`  out  1  line valid, active high.
- `data`  out  8  pixel byte; 0 whenever `href` is low.
- `busy`  out  1  high in any state except IDLE.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.
- `frame_cnt`  out  8  frames completed since accepted `start`; wraps at 256.

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Every line in every state lasts exactly `H_ACTIVE+H_BLANK` clocks.
- Counters: `x` (0..`H_ACTIVE+H_BLANK`-1, wraps every line); `y` (line within current state, cleared on each state change); a frame-remaining counter.
- IDLE: all outputs 0. On `start`=1, latch `num_frames` and `pattern_sel`, clear `frame_cnt`, `x` and `y`, and enter VSYNC.
- VSYNC: `vsync`=1 for `VSYNC_LINES` lines, then VBACK.
- VBACK: `V_BACK` lines, then ACTIVE.
- ACTIVE: `href`=1 while `x` < `H_ACTIVE`. After `V_ACTIVE` lines, enter VFRONT.
- VFRONT: `V_FRONT` lines. On its last clock:
  - pulse `frame_done` and increment `frame_cnt`;
  - go to IDLE if `stop_req`=1, or if `num_frames`≠0 and this completes the final frame;
  - otherwise go to VSYNC.
- `stop_req` is evaluated only at the frame boundary, never mid-frame. `stop_req`=1 together with the last frame of a count is a single exit to IDLE.
- `start` outside IDLE is ignored. `num_frames` and `pattern_sel` changes outside IDLE are ignored.
- Gradient pattern: `data` = (`x`[7:0] + `y`[7:0]) mod 256, where `y` is the active line index.

## Timing
- All outputs are registered; all values shown are post-reset or post-clock-edge.
- Reset: every output is 0 and the state is IDLE. Reset asserted mid-frame forces all outputs to 0 asynchronously, with no partial-frame completion.
- Start latency: `start` is sampled high at edge N. At edge N+1, `vsync`=1 and `busy`=1.
- First `href` rise: (`VSYNC_LINES`+`V_BACK`)·(`H_ACTIVE`+`H_BLANK`) clocks after `vsync` rise.
- `data` changes on the same edge as `href`. It is stable for a full `px_clk` period, so the receiver samples on the next posedge.
- Frame period: (`VSYNC_LINES`+`V_BACK`+`V_ACTIVE`+`V_FRONT`)·(`H_ACTIVE`+`H_BLANK`) clocks.
- Back-to-back frames: `vsync` rises on the clock after `frame_done`. `busy` falls on the clock after the final `frame_done`.

## Configuration
- `DVP_COLORBAR_EN` defined: `pattern_sel`=1 selects colour bars, `data` = `bar`·8'h20 with `bar` = `x`/(`H_ACTIVE`/8), giving 0x00..0xE0.
- Not defined: the bar logic is absent, `pattern_sel` is ignored, and the gradient is always produced.

## Structure
- Shared package `dvp_pkg` holds:
  - the state enum;
  - the default timing constants (640/160/480/4/16/8);
  - the bar step constant 8'h20.
- One natural sub-module, `dvp_pattern_gen`: combinational-plus-output-register mapping (`x`, `y`, `pattern_sel`, `href`) to `data`. The FSM and counters stay in the top.

## Test plan
All benches use `H_ACTIVE`=8, `H_BLANK`=4, `V_ACTIVE`=4, `VSYNC_LINES`=1, `V_BACK`=1, `V_FRONT`=1 (frame = 84 clocks).
- Reset then idle 20 clocks -> `vsync`, `href`, `data`, `busy`, `frame_done` all 0; `start` while `rst_n`=0 ignored.
- `start` with `num_frames`=1, gradient -> `vsync` high clocks 1–12; `href` high 8 clocks per line on 4 lines; line 2 `data` = 02..09; `frame_done` at clock 84; `frame_cnt`=1; `busy` low at clock 85.
- `num_frames`=3 -> three `frame_done` pulses, 84 clocks apart; `vsync` re-rises the clock after each of the first two; `frame_cnt`=3.
- `num_frames`=0, `stop_req` raised at clock 100 -> frame 2 completes; IDLE after the `frame_done` at clock 168; `frame_cnt`=2.
- With `DVP_COLORBAR_EN`, `pattern_sel`=1 -> each active line `data` = 00,20,40,…,E0. Without the macro -> gradient regardless of `pattern_sel`.
- `rst_n` dropped at clock 40 (mid-ACTIVE) -> all outputs 0 immediately. After release, a new `start` gives a clean frame from VSYNC.

Source files
------------

// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared states, default timing and pattern constants for dvp_timing_gen
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_BLANK     = 160;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_VSYNC_LINES = 4;
  localparam int DEF_V_BACK      = 16;
  localparam int DEF_V_FRONT     = 8;

  localparam logic [7:0] BAR_STEP = 8'h20;

endpackage

// File: rtl/dvp_timing_gen_if.sv
// rtl/dvp_timing_gen_if.sv - DVP sensor-side video bus (vsync, href, pixel byte)
interface dvp_timing_gen_if;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output vsync, output href, output data);
  modport slave  (input  vsync, input  href, input  data);
endinterface

// File: rtl/dvp_pattern_gen.sv
// rtl/dvp_pattern_gen.sv - registered test-pattern byte from pixel position
// Colour bars only exist when DVP_COLORBAR_EN is defined; otherwise gradient only.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int XW       = 10
) (
  input  logic          px_clk,
  input  logic          rst_n,
  input  logic [XW-1:0] x,
  input  logic [7:0]    y,
  input  logic          pattern_sel,
  input  logic          en,
  output logic [7:0]    data
);

  logic [7:0] pix;
  logic [7:0] x8;

  assign x8 = 8'(x);

`ifdef DVP_COLORBAR_EN
  localparam logic [XW-1:0] BAR_W = XW'(H_ACTIVE / 8);
  logic [7:0] bar;
  assign bar = 8'(x / BAR_W);
`else
  logic unused_cfg;
  assign unused_cfg = ^{x, pattern_sel};
`endif

  always_comb begin
    pix = x8 + y;
`ifdef DVP_COLORBAR_EN
    if (pattern_sel) pix = bar * BAR_STEP;
`endif
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= en ? pix : 8'h00;
  end

endmodule

// File: rtl/dvp_timing_gen.sv
// rtl/dvp_timing_gen.sv - DVP frame timing generator emitting N test-pattern frames per start
// Optional colour-bar pattern enabled by DVP_COLORBAR_EN.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic                   px_clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             num_frames,
  input  logic                   stop_req,
  input  logic                   pattern_sel,
  dvp_timing_gen_if.master       dvp,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt
);

  localparam int LINE   = H_ACTIVE + H_BLANK;
  localparam int V_MAX1 = (V_ACTIVE > VSYNC_LINES ? V_ACTIVE : VSYNC_LINES);
  localparam int V_MAX2 = (V_BACK > V_FRONT ? V_BACK : V_FRONT);
  localparam int V_MAX  = (V_MAX1 > V_MAX2 ? V_MAX1 : V_MAX2);
  localparam int XW     = $clog2(LINE);
  localparam int YW     = $clog2(V_MAX + 1);

  localparam logic [XW-1:0] X_LAST = XW'(LINE - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);

  state_t        state_q, next_state;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [YW-1:0] lines_last;
  logic [7:0]    frames_left_q;
  logic          sel_q;
  logic          line_end, state_end, frame_end, href_en;
  logic          vsync_q, href_q;
  logic [7:0]    data_w;

  assign line_end  = (x_q == X_LAST);
  assign state_end = line_end && (y_q == lines_last) && (state_q != IDLE);
  assign frame_end = state_end && (state_q == VFRONT);
  assign href_en   = (state_q == ACTIVE) && (x_q < X_ACT);

  always_comb begin
    lines_last = '0;
    next_state = state_q;
    case (state_q)
      VSYNC:   lines_last = YW'(VSYNC_LINES - 1);
      VBACK:   lines_last = YW'(V_BACK - 1);
      ACTIVE:  lines_last = YW'(V_ACTIVE - 1);
      VFRONT:  lines_last = YW'(V_FRONT - 1);
      default: lines_last = '0;
    endcase
    case (state_q)
      IDLE:    if (start)     next_state = VSYNC;
      VSYNC:   if (state_end) next_state = VBACK;
      VBACK:   if (state_end) next_state = ACTIVE;
      ACTIVE:  if (state_end) next_state = VFRONT;
      // frames_left of 0 means continuous, so only an explicit count can reach 1
      VFRONT:  if (state_end) next_state = (stop_req || frames_left_q == 8'd1) ? IDLE : VSYNC;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      frames_left_q <= '0;
      sel_q         <= 1'b0;
      frame_cnt     <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == IDLE) begin
        x_q <= '0;
        y_q <= '0;
        if (start) begin
          frames_left_q <= num_frames;
          sel_q         <= pattern_sel;
          frame_cnt     <= '0;
        end
      end else begin
        x_q <= line_end ? '0 : x_q + 1'b1;
        if (state_end)     y_q <= '0;
        else if (line_end) y_q <= y_q + 1'b1;
        if (frame_end) begin
          frame_cnt <= frame_cnt + 8'd1;
          if (frames_left_q != 8'd0) frames_left_q <= frames_left_q - 8'd1;
        end
      end
      vsync_q    <= (state_q == VSYNC);
      href_q     <= href_en;
      busy       <= (state_q != IDLE);
      frame_done <= frame_end;
    end
  end

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pattern (
    .px_clk      (px_clk),
    .rst_n       (rst_n),
    .x           (x_q),
    .y           (8'(y_q)),
    .pattern_sel (sel_q),
    .en          (href_en),
    .data        (data_w)
  );

  assign dvp.vsync = vsync_q;
  assign dvp.href  = href_q;
  assign dvp.data  = data_w;

endmodule

// File: tb/tb_dvp_timing_gen.sv
// tb/tb_dvp_timing_gen.sv - directed self-checking bench for dvp_timing_gen (12-clock lines, 84-clock frames)
module tb_dvp_timing_gen;

  logic       px_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop_req = 1'b0;
  logic       pattern_sel = 1'b0;
  logic [7:0] num_frames = 8'd0;
  logic       busy, frame_done;
  logic [7:0] frame_cnt;
  int         checks = 0;
  int         errors = 0;

  dvp_timing_gen_if dvp_if ();

  dvp_timing_gen #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .px_clk      (px_clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_frames  (num_frames),
    .stop_req    (stop_req),
    .pattern_sel (pattern_sel),
    .dvp         (dvp_if),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always #5 px_clk = ~px_clk;

  task automatic tick;
    @(posedge px_clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] nf, input logic sel);
    num_frames  = nf;
    pattern_sel = sel;
    start       = 1'b1;
    tick();
    start      = 1'b0;
    num_frames = 8'd7;
  endtask

  // Expected bus for frame-relative state cycle s: line 0 vsync, line 1 back porch,
  // lines 2..5 active (8 pixels then 4 blank), line 6 front porch.
  function automatic logic e_vsync(int s);
    return (s / 12) == 0;
  endfunction

  function automatic logic e_href(int s);
    return (s / 12) >= 2 && (s / 12) <= 5 && (s % 12) < 8;
  endfunction

  function automatic logic [7:0] e_data(int s, logic bars);
    if (!e_href(s)) return 8'h00;
`ifdef DVP_COLORBAR_EN
    if (bars) return 8'((s % 12) * 32);
`endif
    return 8'((s % 12) + (s / 12 - 2));
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    num_frames = 8'd1;
    repeat (3) tick();
    checks++;
    if ({dvp_if.vsync, dvp_if.href, dvp_if.data, busy, frame_done, frame_cnt} !== 20'h0) begin
      errors++;
      $display("FAIL reset_hold got v=%b h=%b d=%h b=%b fd=%b fc=%h exp all 0",
               dvp_if.vsync, dvp_if.href, dvp_if.data, busy, frame_done, frame_cnt);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if ({dvp_if.vsync, dvp_if.href, dvp_if.data, busy, frame_done} !== 12'h0) begin
        errors++;
        $display("FAIL idle c=%0d got v=%b h=%b d=%h b=%b fd=%b exp all 0",
                 c, dvp_if.vsync, dvp_if.href, dvp_if.data, busy, frame_done);
      end
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] line2 [8];
    int s;
    logic inf;
    launch(8'd1, 1'b0);
    for (int c = 1; c <= 90; c++) begin
      tick();
      s   = c - 1;
      inf = (c <= 84);
      if (c >= 49 && c <= 56) line2[c-49] = dvp_if.data;
      checks += 5;
      if (dvp_if.vsync !== (inf && e_vsync(s))) begin
        errors++; $display("FAIL single_vsync c=%0d got %b exp %b", c, dvp_if.vsync, inf && e_vsync(s));
      end
      if (dvp_if.href !== (inf && e_href(s))) begin
        errors++; $display("FAIL single_href c=%0d got %b exp %b", c, dvp_if.href, inf && e_href(s));
      end
      if (dvp_if.data !== (inf ? e_data(s, 1'b0) : 8'h00)) begin
        errors++; $display("FAIL single_data c=%0d got %h exp %h", c, dvp_if.data, inf ? e_data(s, 1'b0) : 8'h00);
      end
      if (frame_done !== (c == 84)) begin
        errors++; $display("FAIL single_done c=%0d got %b exp %b", c, frame_done, c == 84);
      end
      if (busy !== inf) begin
        errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy, inf);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (line2[i] !== 8'(i + 2)) begin
        errors++; $display("FAIL line2_data i=%0d got %h exp %h", i, line2[i], 8'(i + 2));
      end
    end
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL single_frame_cnt got %0d exp 1", frame_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int s;
    logic inf;
    launch(8'd3, 1'b0);
    for (int c = 1; c <= 260; c++) begin
      tick();
      s   = (c - 1) % 84;
      inf = (c <= 252);
      checks += 3;
      if (frame_done !== (inf && s == 83)) begin
        errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, frame_done, inf && s == 83);
      end
      if (dvp_if.vsync !== (inf && e_vsync(s))) begin
        errors++; $display("FAIL b2b_vsync c=%0d got %b exp %b", c, dvp_if.vsync, inf && e_vsync(s));
      end
      if (busy !== inf) begin
        errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, inf);
      end
    end
    checks++;
    if (frame_cnt !== 8'd3) begin
      errors++; $display("FAIL b2b_frame_cnt got %0d exp 3", frame_cnt);
    end
  endtask

  task automatic test_stop;
    int s;
    logic inf;
    launch(8'd0, 1'b0);
    for (int c = 1; c <= 260; c++) begin
      tick();
      s   = (c - 1) % 84;
      inf = (c <= 168);
      checks += 3;
      if (frame_done !== (inf && s == 83)) begin
        errors++; $display("FAIL stop_done c=%0d got %b exp %b", c, frame_done, inf && s == 83);
      end
      if (dvp_if.href !== (inf && e_href(s))) begin
        errors++; $display("FAIL stop_href c=%0d got %b exp %b", c, dvp_if.href, inf && e_href(s));
      end
      if (busy !== inf) begin
        errors++; $display("FAIL stop_busy c=%0d got %b exp %b", c, busy, inf);
      end
      if (c == 100) stop_req = 1'b1;
    end
    stop_req = 1'b0;
    checks++;
    if (frame_cnt !== 8'd2) begin
      errors++; $display("FAIL stop_frame_cnt got %0d exp 2", frame_cnt);
    end
  endtask

  task automatic test_pattern;
    int s;
    launch(8'd1, 1'b1);
    for (int c = 1; c <= 84; c++) begin
      tick();
      s = c - 1;
      checks++;
      if (dvp_if.data !== e_data(s, 1'b1)) begin
        errors++; $display("FAIL pattern_data c=%0d got %h exp %h", c, dvp_if.data, e_data(s, 1'b1));
      end
      if (c == 30) pattern_sel = 1'b0;
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_midframe;
    launch(8'd1, 1'b0);
    repeat (39) tick();
    checks++;
    if (dvp_if.href !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_active got h=%b b=%b exp h=1 b=1", dvp_if.href, busy);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({dvp_if.vsync, dvp_if.href, dvp_if.data, busy, frame_done, frame_cnt} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b h=%b d=%h b=%b fd=%b fc=%h exp all 0",
               dvp_if.vsync, dvp_if.href, dvp_if.data, busy, frame_done, frame_cnt);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    launch(8'd1, 1'b0);
    for (int c = 1; c <= 85; c++) begin
      tick();
      checks += 2;
      if (dvp_if.vsync !== (c <= 12)) begin
        errors++; $display("FAIL restart_vsync c=%0d got %b exp %b", c, dvp_if.vsync, c <= 12);
      end
      if (frame_done !== (c == 84)) begin
        errors++; $display("FAIL restart_done c=%0d got %b exp %b", c, frame_done, c == 84);
      end
    end
    checks += 2;
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL restart_frame_cnt got %0d exp 1", frame_cnt);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL restart_busy got %b exp 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stop();
    test_pattern();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
